// File: rtl/dmem_lsu.sv
// Load/store unit between the single-cycle core data port and a variable-latency
// data memory: formats stores, extracts/extends loads, stalls the core meanwhile.
module dmem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        dmtype_q;
  logic [1:0]        lane_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       rdata_q;
  logic              rdata_valid_q;
  logic              bus_err_q;

  logic        is_half, is_byte, aligned;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  // Unused codes 101-111 fall through to word handling.
  always_comb begin
    is_half = (req_dmtype == 3'b001) || (req_dmtype == 3'b010);
    is_byte = (req_dmtype == 3'b011) || (req_dmtype == 3'b100);
    if (is_half)      aligned = ~req_addr[0];
    else if (is_byte) aligned = 1'b1;
    else              aligned = (req_addr[1:0] == 2'b00);
  end

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = req_wdata;
    if (is_half) begin
      fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      fmt_wdata = {2{req_wdata[15:0]}};
    end else if (is_byte) begin
      fmt_be    = 4'b0001 << req_addr[1:0];
      fmt_wdata = {4{req_wdata[7:0]}};
    end
    if (!req_we) fmt_be = 4'b1111;
  end

  always_comb begin
    lane_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (dmtype_q)
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = {16'h0000, lane_half};
      3'b011:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {24'h000000, lane_byte};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      dmtype_q      <= 3'b000;
      lane_q        <= 2'b00;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_be_q      <= 4'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && aligned) begin
            dmtype_q    <= req_dmtype;
            lane_q      <= req_addr[1:0];
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_wdata_q <= fmt_wdata;
            mem_be_q    <= fmt_be;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (mem_ready) begin
            if (!mem_we_q) rdata_q <= load_data;
            rdata_valid_q <= ~mem_we_q;
            mem_req_q     <= 1'b0;
            state_q       <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            bus_err_q     <= 1'b1;
            rdata_q       <= 32'h0;
            rdata_valid_q <= ~mem_we_q;
            mem_req_q     <= 1'b0;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          rdata_valid_q <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall        = ((state_q == S_IDLE) && req_valid && aligned) || (state_q == S_BUSY);
  assign misalign_err = (state_q == S_IDLE) && req_valid && !aligned;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign bus_err      = bus_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus random accesses checked against an
// arithmetic model of store formatting, load extraction, latency and timeout.
module tb_dmem_lsu;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_dmtype;
  logic        stall, rdata_valid, misalign_err, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic        exp_bus_err = 1'b0;

  dmem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] dt);
    int unsigned b, h;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (16 * ((a / 2) % 2))) % 65536;
    case (dt)
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic we, input logic [31:0] a, input logic [2:0] dt);
    if (!we) return 4'hF;
    if (dt == 1 || dt == 2) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
    if (dt == 3 || dt == 4) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input logic [31:0] d, input logic [2:0] dt);
    if (dt == 1 || dt == 2) return (d % 65536) * 32'h00010001;
    if (dt == 3 || dt == 4) return (d % 256) * 32'h01010101;
    return d;
  endfunction

  // lat = BUSY cycles before mem_ready; lat >= TIMEOUT means memory never answers.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] dt, input int lat, input logic [31:0] rd);
    bit is_h, is_b, aligned, timed_out;
    int k, stalls;
    is_h = (dt == 1 || dt == 2);
    is_b = (dt == 3 || dt == 4);
    aligned = is_h ? (addr % 2 == 0) : (is_b ? 1'b1 : (addr % 4 == 0));
    timed_out = (lat >= TIMEOUT);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = dt;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    if (!aligned) begin
      check("misalign_err", misalign_err, 1);
      check("misalign_stall", stall, 0);
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b0;
      #1;
      check("misalign_noreq", mem_req, 0);
      check("misalign_pulse_end", misalign_err, 0);
      return;
    end
    check("issue_stall", stall, 1);
    check("issue_misalign", misalign_err, 0);
    if (!we) exp_q.push_back(timed_out ? 32'h0 : load_model(rd, addr, dt));
    stalls = 1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      #1;
      if (k == 0) begin
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, addr & 32'hFFFFFFFC);
        check("mem_we", mem_we, we);
        check("mem_be", mem_be, be_model(we, addr, dt));
        if (we) check("mem_wdata", mem_wdata, wd_model(wdata, dt));
      end
      if (!stall) break;
      stalls++;
    end
    mem_ready = 1'b0;
    check("done_reached", k < 40, 1);
    check("stall_cycles", stalls, timed_out ? TIMEOUT + 1 : lat + 2);
    check("done_mem_req", mem_req, 0);
    check("done_rdata_valid", rdata_valid, !we);
    if (timed_out) exp_bus_err = 1'b1;
    check("bus_err", bus_err, exp_bus_err);
    if (rdata_valid) begin
      if (exp_q.size() == 0) check("exp_q_nonempty", 0, 1);
      else check("rdata", rdata, exp_q.pop_front());
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("post_rdata_valid", rdata_valid, 0);
    check("post_no_reissue", mem_req, 0);
    check("post_stall", stall, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_dmtype = 3'b000; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    access(1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 3, 32'h0);
    access(1'b1, 32'h203, 32'h000000A5, 3'b011, 0, 32'h0);
    access(1'b0, 32'h42, 32'h0, 3'b011, 1, 32'h80F17F00);
    access(1'b0, 32'h42, 32'h0, 3'b100, 0, 32'h80F17F00);
    access(1'b0, 32'h42, 32'h0, 3'b001, 2, 32'h80F17F00);
    access(1'b0, 32'h102, 32'h0, 3'b000, 0, 32'h0);
    access(1'b0, 32'h101, 32'h0, 3'b010, 0, 32'h0);
    access(1'b0, 32'h300, 32'h0, 3'b000, TIMEOUT - 1, 32'h12345678);
    access(1'b1, 32'h302, 32'h0000BEEF, 3'b001, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), $urandom & 32'h0000FFFF, $urandom,
             3'($urandom_range(0, 7)), $urandom_range(0, 6), $urandom);
    end

    access(1'b0, 32'h400, 32'h0, 3'b000, TIMEOUT, 32'hCAFEF00D);
    access(1'b0, 32'h404, 32'h0, 3'b100, 1, 32'h11223344);

    // Reset while the memory is still working on a load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_dmtype = 3'b000; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rstbusy_in_busy", mem_req, 1);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rstbusy_state", dbg_state, 0);
    check("rstbusy_mem_req", mem_req, 0);
    check("rstbusy_stall", stall, 0);
    check("rstbusy_rdata_valid", rdata_valid, 0);
    check("rstbusy_bus_err", bus_err, 0);
    reset = 1'b0;
    exp_bus_err = 1'b0;
    access(1'b0, 32'h600, 32'h0, 3'b000, 2, 32'hA5A55A5A);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
